// File: rtl/uart_core.sv
// UART transceiver: TX FIFO feeding a serialiser, 2-flop-synchronised receiver with a one-word holding register.
// uart_tx goes low two cycles after a word is accepted into an empty FIFO; tx_ready drops when the FIFO is full; an unaccepted received word is dropped and rx_overrun pulses.
module uart_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int TX_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 uart_tx,
  input  logic                 uart_rx
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        ODD_PAR   = 1'(PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  logic [DATA_BITS-1:0] fifo_q [TX_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_e               tx_state_q;
  logic [15:0]          tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q, uart_tx_q, tx_tick, tx_stop_done;

  assign tx_ready     = (count_q != (AW+1)'(TX_DEPTH));
  assign push         = tx_valid && tx_ready;
  assign head         = fifo_q[rd_ptr_q];
  assign tx_tick      = (tx_cnt_q == BIT_LAST);
  assign tx_stop_done = (tx_state_q == S_STOP) && tx_tick && (tx_bit_q == STOP_LAST);
  // Popping at the end of the last stop bit gives back-to-back frames with no idle gap.
  assign pop          = (count_q != '0) && ((tx_state_q == S_IDLE) || tx_stop_done);
  assign tx_busy      = (count_q != '0) || (tx_state_q != S_IDLE);
  assign uart_tx      = uart_tx_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      uart_tx_q  <= 1'b1;
    end else begin
      // Line level follows the state one cycle later, so every bit keeps its full width.
      case (tx_state_q)
        S_START: uart_tx_q <= 1'b0;
        S_DATA:  uart_tx_q <= tx_shift_q[0];
        S_PAR:   uart_tx_q <= tx_par_q;
        default: uart_tx_q <= 1'b1;
      endcase
      tx_cnt_q <= (tx_state_q == S_IDLE || tx_tick) ? '0 : tx_cnt_q + 16'd1;
      if (pop) begin
        tx_shift_q <= head;
        tx_par_q   <= (^head) ^ ODD_PAR;
        tx_bit_q   <= '0;
        tx_state_q <= S_START;
      end else if (tx_tick) begin
        case (tx_state_q)
          S_START: begin
            tx_bit_q   <= '0;
            tx_state_q <= S_DATA;
          end
          S_DATA: begin
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 3'd1;
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_q   <= '0;
              tx_state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end
          end
          S_PAR: begin
            tx_bit_q   <= '0;
            tx_state_q <= S_STOP;
          end
          S_STOP: begin
            tx_bit_q <= tx_bit_q + 3'd1;
            if (tx_bit_q == STOP_LAST) tx_state_q <= S_IDLE;
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_e               rx_state_q;
  logic [15:0]          rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
  logic                 rx_perr_q, rx_valid_q, rx_ferr_out_q, rx_perr_out_q, rx_ovr_q, rx_tick;

  assign rx_tick       = (rx_cnt_q == BIT_LAST);
  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_frame_err  = rx_ferr_out_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_overrun    = rx_ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= S_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_perr_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_ferr_out_q <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_ovr_q  <= 1'b0;
      rx_cnt_q  <= rx_cnt_q + 16'd1;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_state_q <= S_START;
        end
        S_START: if (rx_cnt_q == HALF_LAST) begin
          // Start bit high at its midpoint is treated as a glitch.
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_perr_q  <= 1'b0;
          rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_tick) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == DATA_LAST) rx_state_q <= (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: if (rx_tick) begin
          rx_cnt_q   <= '0;
          rx_perr_q  <= rx_s2_q ^ (^rx_shift_q) ^ ODD_PAR;
          rx_state_q <= S_STOP;
        end
        S_STOP: if (rx_tick) begin
          rx_cnt_q   <= '0;
          rx_state_q <= S_IDLE;
          if (!rx_valid_q || rx_ready) begin
            rx_valid_q    <= 1'b1;
            rx_data_q     <= rx_shift_q;
            rx_ferr_out_q <= !rx_s2_q;
            rx_perr_out_q <= rx_perr_q;
          end else begin
            rx_ovr_q <= 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per UART bit; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1, stop bits transmitted; legal values 1 or 2.
REQ-005 Parameter TX_DEPTH, default 4, TX FIFO entries; power of 2, >= 2.
REQ-006 Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- tx_valid  in  1  TX write request.
- tx_ready  out  1  TX FIFO not full.
- tx_data  in  DATA_BITS  TX word.
- tx_busy  out  1  FIFO non-empty or frame in flight.
- rx_valid  out  1  received word held.
- rx_ready  in  1  consumer accepts held word.
- rx_data  out  DATA_BITS  received word.
- rx_frame_err  out  1  stop bit of held word sampled 0.
- rx_parity_err  out  1  parity mismatch on held word.
- rx_overrun  out  1  one-cycle pulse; frame dropped.
- uart_tx  out  1  serial out; idle 1.
- uart_rx  in  1  serial in; asynchronous.

Function
REQ-007 Single clock domain; bit timing from a per-direction counter counting 0..CLKS_PER_BIT-1; no external baud clock.
REQ-008 TX write: word enters FIFO on a clk edge where tx_valid && tx_ready; tx_ready = !full; a write while full is ignored.
REQ-009 TX FSM states: IDLE, START, DATA, PAR, STOP; each state except IDLE lasts exactly CLKS_PER_BIT cycles per bit.
REQ-010 IDLE: if FIFO non-empty, pop head into shift register and enter START on the same edge.
REQ-011 uart_tx is registered: 0 in START, shift[0] in DATA (LSB first), parity bit in PAR, 1 in STOP/IDLE.
REQ-012 Latency: word accepted into empty FIFO at edge k while IDLE -> uart_tx = 0 from edge k+2.
REQ-013 DATA shifts after each bit; leaves after DATA_BITS bits to PAR if PARITY != 0, else STOP.
REQ-014 Parity bit = XOR of data bits (even) or its inverse (odd).
REQ-015 STOP lasts STOP_BITS*CLKS_PER_BIT cycles, then IDLE; a non-empty FIFO starts the next frame back-to-back with no extra idle bit.
REQ-016 Simultaneous push and pop with FIFO full is legal: pop frees a slot only on the next cycle (tx_ready reflects pre-pop count).
REQ-017 tx_busy = FIFO non-empty or TX FSM != IDLE.
REQ-018 RX input passes a 2-flop synchroniser, both flops reset to 1; all RX logic uses the synchronised value.
REQ-019 RX FSM states: IDLE, START, DATA, PAR, STOP.
REQ-020 IDLE: synchronised 1->0 transition enters START, counter cleared.
REQ-021 START: sample at count CLKS_PER_BIT/2-1 (integer division); if 1, glitch -> IDLE with no output; if 0, continue.
REQ-022 DATA/PAR/STOP: sample one bit every CLKS_PER_BIT cycles from the start-bit midpoint; data assembled LSB first.
REQ-023 Only the first stop bit is checked; the receiver returns to IDLE at the stop-bit sample point.
REQ-024 At the stop sample: if rx_valid=0 or (rx_valid && rx_ready) that cycle, load rx_data, rx_frame_err, rx_parity_err and set rx_valid=1.
REQ-025 Otherwise the frame is discarded, held word unchanged, rx_overrun=1 for one cycle.
REQ-026 rx_valid clears on the edge where rx_valid && rx_ready, unless reloaded per REQ-024 on the same edge.
REQ-027 With PARITY=0, rx_parity_err is always 0.

Reset
REQ-028 On rst: TX and RX FSMs to IDLE, counters 0, FIFO emptied, uart_tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, both error flags 0, rx_overrun=0, synchroniser flops 1.
REQ-029 rst mid-frame aborts the frame: uart_tx returns to 1 on the reset edge; FIFO contents are lost; a partially received word is dropped.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1, TX_DEPTH=4 unless stated)
REQ-030 Write 0xA5 at edge k -> uart_tx = 0 at k+2, then bits 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 4 cycles; tx_busy drops after 44 cycles of frame.
REQ-031 Loop uart_tx to uart_rx, write 0x00, 0xFF, 0x3C -> rx_data sequence 0x00, 0xFF, 0x3C, each error flag 0; tx_ready drops after 5th unpopped write when 5 writes are issued back-to-back.
REQ-032 Drive frame 0x55 with stop bit 0 -> rx_valid=1, rx_data=0x55, rx_frame_err=1; drive frame 0x01 with parity bit 0 -> rx_parity_err=1.
REQ-033 Hold rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses once at the 0x22 stop sample.
REQ-034 1-cycle low glitch on uart_rx -> no rx_valid; assert rst in TX DATA state -> uart_tx=1 next cycle, tx_ready=1, tx_busy=0.
REQ-035 PARITY=0, STOP_BITS=2, DATA_BITS=7: send 0x7F -> frame of 10 bits (start, 7 data, 2 stop) = 40 cycles; received rx_data=0x7F.
